acq_scheduler: RTL

- Serial-search acquisition sequencer for the C/A code generator and its correlator.
- Steps through satellite PRN selects and half-chip code-phase hypotheses by driving sat, dither, slip and generator reset.
- Integrates correlator magnitude over a fixed number of code epochs, compares against a threshold, and reports lock (sat, phase, magnitude) or search exhaustion.

---
 rtl/acq_scheduler.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/acq_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : acq_scheduler
// Brief   : Serial-search C/A acquisition sequencer (sat x half-chip phase).
//           Optional macro ACQ_PEAK_SEARCH_EN: lock on strongest crossing per sat.
// Rev     : 1.0
// ============================================================================
module acq_scheduler #(
    parameter int DWELL_EPOCHS = 4,
    parameter int ACC_W        = 16,
    parameter int NPHASE       = 2046,
    parameter int PH_W         = 11,
    parameter int SAT_FIRST    = 0,
    parameter int SAT_LAST     = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             epoch,
    input  logic             corr_valid,
    input  logic [11:0]      corr_mag,
    input  logic [ACC_W-1:0] threshold,
    output logic [4:0]       sat,
    output logic             dither,
    output logic             slip,
    output logic             gen_rst,
    output logic             busy,
    output logic             lock,
    output logic [4:0]       lock_sat,
    output logic [PH_W-1:0]  lock_phase,
    output logic [ACC_W-1:0] lock_mag,
    output logic             done_nolock
);
    localparam int              c_ec_w      = (DWELL_EPOCHS < 2) ? 1 : $clog2(DWELL_EPOCHS);
    localparam int              c_sum_w     = ((ACC_W > 12) ? ACC_W : 12) + 1;
    localparam logic [c_ec_w-1:0] c_ep_last = c_ec_w'(DWELL_EPOCHS - 1);
    localparam logic [ACC_W-1:0] c_acc_max  = {ACC_W{1'b1}};
    localparam logic [PH_W-1:0]  c_ph_last  = PH_W'(NPHASE - 1);
    localparam logic [4:0]       c_sat_first = 5'(SAT_FIRST);
    localparam logic [4:0]       c_sat_last  = 5'(SAT_LAST);

    typedef enum logic [3:0] {
        S_IDLE, S_GENRST, S_SYNC, S_DWELL, S_EVAL, S_STEP, S_NEXTSAT, S_LOCKED, S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_epoch_d;
    logic [c_ec_w-1:0]   r_ecnt, w_ecnt_nxt;
    logic [ACC_W-1:0]    r_acc, w_acc_nxt, w_acc_inc;
    logic [PH_W-1:0]     r_phase, w_phase_nxt, w_ph_inc;
    logic [4:0]          r_sat, w_sat_nxt;
    logic                r_dither, w_dither_nxt;
    logic                r_slip, w_slip_nxt;
    logic                r_gen_rst, w_gen_rst_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_lock, w_lock_nxt;
    logic                r_done, w_done_nxt;
    logic [4:0]          r_lock_sat, w_lock_sat_nxt;
    logic [PH_W-1:0]     r_lock_phase, w_lock_phase_nxt;
    logic [ACC_W-1:0]    r_lock_mag, w_lock_mag_nxt;
    logic [c_sum_w-1:0]  w_sum;
    logic                w_ep_edge, w_hit, w_last_ph;
`ifdef ACQ_PEAK_SEARCH_EN
    logic                r_pk_found, w_pk_found_nxt, w_better;
    logic [ACC_W-1:0]    r_pk_mag, w_pk_mag_nxt;
    logic [PH_W-1:0]     r_pk_phase, w_pk_phase_nxt;
`endif

    always_comb begin
        w_ep_edge = epoch & ~r_epoch_d;
        w_sum     = c_sum_w'(r_acc) + c_sum_w'(corr_mag);
        w_acc_inc = (w_sum > c_sum_w'(c_acc_max)) ? c_acc_max : w_sum[ACC_W-1:0];
        w_hit     = (r_acc >= threshold);
        w_last_ph = (r_phase == c_ph_last);
        w_ph_inc  = r_phase + PH_W'(1);

        w_state_nxt      = r_state;
        w_ecnt_nxt       = r_ecnt;
        w_acc_nxt        = r_acc;
        w_phase_nxt      = r_phase;
        w_sat_nxt        = r_sat;
        w_dither_nxt     = r_dither;
        w_busy_nxt       = r_busy;
        w_lock_nxt       = r_lock;
        w_done_nxt       = r_done;
        w_lock_sat_nxt   = r_lock_sat;
        w_lock_phase_nxt = r_lock_phase;
        w_lock_mag_nxt   = r_lock_mag;
`ifdef ACQ_PEAK_SEARCH_EN
        // Ties keep the earlier phase: only a strictly larger crossing replaces.
        w_better       = w_hit && (!r_pk_found || (r_acc > r_pk_mag));
        w_pk_found_nxt = r_pk_found;
        w_pk_mag_nxt   = r_pk_mag;
        w_pk_phase_nxt = r_pk_phase;
`endif

        case (r_state)
            S_IDLE, S_LOCKED, S_DONE: begin
                if (start) begin
                    w_sat_nxt    = c_sat_first;
                    w_phase_nxt  = '0;
                    w_dither_nxt = 1'b0;
                    w_lock_nxt   = 1'b0;
                    w_done_nxt   = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_GENRST;
                end
            end
            S_GENRST: begin
`ifdef ACQ_PEAK_SEARCH_EN
                w_pk_found_nxt = 1'b0;
`endif
                w_state_nxt = S_SYNC;
            end
            S_SYNC: begin
                // Hold the integrator clear until an epoch boundary so a partial epoch never counts.
                w_acc_nxt  = '0;
                w_ecnt_nxt = '0;
                if (w_ep_edge) w_state_nxt = S_DWELL;
            end
            S_DWELL: begin
                if (corr_valid) w_acc_nxt = w_acc_inc;
                if (w_ep_edge) begin
                    if (r_ecnt == c_ep_last) w_state_nxt = S_EVAL;
                    else                     w_ecnt_nxt  = r_ecnt + c_ec_w'(1);
                end
            end
            S_EVAL: begin
`ifdef ACQ_PEAK_SEARCH_EN
                if (w_better) begin
                    w_pk_found_nxt = 1'b1;
                    w_pk_mag_nxt   = r_acc;
                    w_pk_phase_nxt = r_phase;
                end
                if (w_last_ph && (w_better || r_pk_found)) begin
                    w_state_nxt      = S_LOCKED;
                    w_lock_nxt       = 1'b1;
                    w_busy_nxt       = 1'b0;
                    w_lock_sat_nxt   = r_sat;
                    w_lock_phase_nxt = w_better ? r_phase : r_pk_phase;
                    w_lock_mag_nxt   = w_better ? r_acc : r_pk_mag;
                end else begin
                    w_state_nxt = S_STEP;
                end
`else
                if (w_hit) begin
                    w_state_nxt      = S_LOCKED;
                    w_lock_nxt       = 1'b1;
                    w_busy_nxt       = 1'b0;
                    w_lock_sat_nxt   = r_sat;
                    w_lock_phase_nxt = r_phase;
                    w_lock_mag_nxt   = r_acc;
                end else begin
                    w_state_nxt = S_STEP;
                end
`endif
            end
            S_STEP: begin
                if (w_last_ph) begin
                    w_state_nxt = S_NEXTSAT;
                end else begin
                    w_phase_nxt  = w_ph_inc;
                    w_dither_nxt = w_ph_inc[0];
                    w_state_nxt  = S_SYNC;
                end
            end
            S_NEXTSAT: begin
                if (r_sat == c_sat_last) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_sat_nxt    = r_sat + 5'd1;
                    w_phase_nxt  = '0;
                    w_dither_nxt = 1'b0;
                    w_state_nxt  = S_GENRST;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Slip is raised for the whole STEP cycle whenever the step lands on a whole-chip phase.
        w_slip_nxt    = (r_state == S_EVAL) && (w_state_nxt == S_STEP) && !w_last_ph && r_phase[0];
        w_gen_rst_nxt = (w_state_nxt == S_GENRST);

        if (abort) begin
            w_state_nxt   = S_IDLE;
            w_busy_nxt    = 1'b0;
            w_lock_nxt    = 1'b0;
            w_done_nxt    = 1'b0;
            w_slip_nxt    = 1'b0;
            w_gen_rst_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_epoch_d    <= 1'b0;
            r_ecnt       <= '0;
            r_acc        <= '0;
            r_phase      <= '0;
            r_sat        <= c_sat_first;
            r_dither     <= 1'b0;
            r_slip       <= 1'b0;
            r_gen_rst    <= 1'b0;
            r_busy       <= 1'b0;
            r_lock       <= 1'b0;
            r_done       <= 1'b0;
            r_lock_sat   <= '0;
            r_lock_phase <= '0;
            r_lock_mag   <= '0;
`ifdef ACQ_PEAK_SEARCH_EN
            r_pk_found   <= 1'b0;
            r_pk_mag     <= '0;
            r_pk_phase   <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_epoch_d    <= epoch;
            r_ecnt       <= w_ecnt_nxt;
            r_acc        <= w_acc_nxt;
            r_phase      <= w_phase_nxt;
            r_sat        <= w_sat_nxt;
            r_dither     <= w_dither_nxt;
            r_slip       <= w_slip_nxt;
            r_gen_rst    <= w_gen_rst_nxt;
            r_busy       <= w_busy_nxt;
            r_lock       <= w_lock_nxt;
            r_done       <= w_done_nxt;
            r_lock_sat   <= w_lock_sat_nxt;
            r_lock_phase <= w_lock_phase_nxt;
            r_lock_mag   <= w_lock_mag_nxt;
`ifdef ACQ_PEAK_SEARCH_EN
            r_pk_found   <= w_pk_found_nxt;
            r_pk_mag     <= w_pk_mag_nxt;
            r_pk_phase   <= w_pk_phase_nxt;
`endif
        end
    end

    assign sat         = r_sat;
    assign dither      = r_dither;
    assign slip        = r_slip;
    assign gen_rst     = r_gen_rst;
    assign busy        = r_busy;
    assign lock        = r_lock;
    assign done_nolock = r_done;
    assign lock_sat    = r_lock_sat;
    assign lock_phase  = r_lock_phase;
    assign lock_mag    = r_lock_mag;

endmodule
`default_nettype wire
